// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - dual-port memory arbiter with sequenced writes and overlap blocking
// Optional feature macro: MEMARB_PERF_EN (adds perf_stall_cnt stall counter output)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req/req_we               per-requester request and write flag, held until ack
//   req_addr/req_wdata       flattened per-requester byte address and write data
//   ack/rdata                one-cycle completion pulse and shared read data
//   mem_addrA/B, mem_dinA/B  memory port address and write data
//   mem_weA/B, mem_doutA/B   memory port write enable and read data
//   mem_rstz                 memory clear, active-low
//   perf_stall_cnt           (MEMARB_PERF_EN only) saturating stall-cycle counter
module mem_port_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      mem_addrA,
    output logic [DATA_W-1:0]      mem_dinA,
    output logic                   mem_weA,
    input  logic [DATA_W-1:0]      mem_doutA,
    output logic [ADDR_W-1:0]      mem_addrB,
    output logic [DATA_W-1:0]      mem_dinB,
    output logic                   mem_weB,
    input  logic [DATA_W-1:0]      mem_doutB,
    output logic                   mem_rstz
`ifdef MEMARB_PERF_EN
    ,
    output logic [15:0]            perf_stall_cnt
`endif
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t            state_q [2];
    state_t            state_d [2];
    logic [ADDR_W-1:0] addr_q  [2];
    logic [DATA_W-1:0] din_q   [2];
    logic              we_q    [2];   // access in flight is a write
    logic              wen_q   [2];   // registered memory write enable
    logic [IW-1:0]     id_q    [2];
    logic              done    [2];
    logic              gnt_v   [2];
    logic [IW-1:0]     gnt_id  [2];

    logic [NREQ-1:0]   busy_q, grant, cand, ack_raw_q;
    logic [IW-1:0]     ptr_q;
    logic [IW:0]       pick_a, pick_b;
    logic              ob_v, ob_w;
    logic [ADDR_W-1:0] ob_a;
    logic [1:0]        rstz_s;
    logic              skid_v, skid_rd;
    logic [IW-1:0]     skid_id;
    logic [DATA_W-1:0] skid_data;

    // Byte pairs {a, a+1} and {b, b+1} share a byte; the +1 wraps at the top of memory.
    function automatic logic overlap(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a == b) || (a + ADDR_W'(1) == b) || (b + ADDR_W'(1) == a);
    endfunction

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + IW'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] id);
        return NREQ'(1) << id;
    endfunction

    // First eligible candidate in round-robin order from start; {valid, id}.
    function automatic logic [IW:0] pick(
        input logic [NREQ-1:0]        c,
        input logic [IW-1:0]          start,
        input logic [NREQ*ADDR_W-1:0] addrs,
        input logic [NREQ-1:0]        wes,
        input logic                   ov,
        input logic [ADDR_W-1:0]      oa,
        input logic                   ow
    );
        logic [IW:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NREQ) idx -= NREQ;
            if (!r[IW] && c[idx] &&
                !(ov && (ow || wes[idx]) && overlap(addrs[idx*ADDR_W +: ADDR_W], oa)))
                r = {1'b1, IW'(idx)};
        end
        return r;
    endfunction

    always_comb begin
        cand   = req & ~busy_q & {NREQ{mem_rstz}};
        grant  = '0;
        pick_a = pick(cand, ptr_q, req_addr, req_we, state_q[1] != S_IDLE, addr_q[1], we_q[1]);
        gnt_v[0]  = (state_q[0] == S_IDLE) && pick_a[IW];
        gnt_id[0] = pick_a[IW-1:0];
        if (gnt_v[0]) grant[gnt_id[0]] = 1'b1;
        // Port B treats a fresh port-A grant as already in flight.
        if (gnt_v[0]) begin
            ob_v = 1'b1;
            ob_a = req_addr[gnt_id[0]*ADDR_W +: ADDR_W];
            ob_w = req_we[gnt_id[0]];
        end else begin
            ob_v = state_q[0] != S_IDLE;
            ob_a = addr_q[0];
            ob_w = we_q[0];
        end
        pick_b = pick(cand & ~grant, ptr_q, req_addr, req_we, ob_v, ob_a, ob_w);
        gnt_v[1]  = (state_q[1] == S_IDLE) && pick_b[IW];
        gnt_id[1] = pick_b[IW-1:0];
        if (gnt_v[1]) grant[gnt_id[1]] = 1'b1;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            done[p]    = (state_q[p] == S_RD) || (state_q[p] == S_HOLD);
            case (state_q[p])
                S_IDLE:   if (gnt_v[p]) state_d[p] = req_we[gnt_id[p]] ? S_SETUP : S_RD;
                S_RD:     state_d[p] = S_IDLE;
                S_SETUP:  state_d[p] = S_STROBE;
                S_STROBE: state_d[p] = S_HOLD;
                S_HOLD:   state_d[p] = S_IDLE;
                default:  state_d[p] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= S_IDLE;
                addr_q[p]  <= '0;
                din_q[p]   <= '0;
                we_q[p]    <= 1'b0;
                wen_q[p]   <= 1'b0;
                id_q[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                wen_q[p]   <= (state_d[p] == S_STROBE);
                if (gnt_v[p]) begin
                    addr_q[p] <= req_addr[gnt_id[p]*ADDR_W +: ADDR_W];
                    din_q[p]  <= req_wdata[gnt_id[p]*DATA_W +: DATA_W];
                    we_q[p]   <= req_we[gnt_id[p]];
                    id_q[p]   <= gnt_id[p];
                end
            end
        end
    end

    // Completion stage. A requester stays busy through its ack cycle so its still-high
    // req is not mistaken for a new request. A same-cycle B completion goes to the skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack       <= '0;
            ack_raw_q <= '0;
            rdata     <= '0;
            busy_q    <= '0;
            ptr_q     <= '0;
            skid_v    <= 1'b0;
            skid_rd   <= 1'b0;
            skid_id   <= '0;
            skid_data <= '0;
        end else begin
            busy_q    <= (busy_q & ~ack_raw_q) | grant;
            ack       <= '0;
            ack_raw_q <= '0;
            skid_v    <= 1'b0;
            if (gnt_v[1])      ptr_q <= next_id(gnt_id[1]);
            else if (gnt_v[0]) ptr_q <= next_id(gnt_id[0]);
            if (skid_v) begin
                ack_raw_q <= onehot(skid_id);
                ack       <= onehot(skid_id) & req;
                if (skid_rd) rdata <= skid_data;
            end else if (done[0]) begin
                ack_raw_q <= onehot(id_q[0]);
                ack       <= onehot(id_q[0]) & req;
                if (!we_q[0]) rdata <= mem_doutA;
                if (done[1]) begin
                    skid_v    <= 1'b1;
                    skid_id   <= id_q[1];
                    skid_rd   <= !we_q[1];
                    skid_data <= mem_doutB;
                end
            end else if (done[1]) begin
                ack_raw_q <= onehot(id_q[1]);
                ack       <= onehot(id_q[1]) & req;
                if (!we_q[1]) rdata <= mem_doutB;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rstz_s <= 2'b00;
        else     rstz_s <= {rstz_s[0], 1'b1};
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (|(req & ~busy_q & ~grant) && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`endif

    assign mem_rstz  = rstz_s[1];
    assign mem_addrA = addr_q[0];
    assign mem_dinA  = din_q[0];
    assign mem_weA   = wen_q[0];
    assign mem_addrB = addr_q[1];
    assign mem_dinB  = din_q[1];
    assign mem_weB   = wen_q[1];

endmodule
